btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input-conditioning stage placed directly upstream of the counter in the board top.
- Takes raw, asynchronous, bouncing pushbutton levels and synchronises and debounces each one.
- Emits clean debounced levels plus single-cycle press/release pulses.
- Counter's clear is driven from a debounced level; counter's count is driven from a press pulse, giving one increment per physical press.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 270000, stable cycles required to accept a change (10 ms at 27 MHz); legal range >= 2.
- BTN_ACTIVE_LOW, 1, 1 = raw input low means pressed (board pull-ups); 0 = active-high.
- REPEAT_DELAY, 13500000, hold cycles before first auto-repeat pulse (used only with macro).
- REPEAT_PERIOD, 2700000, cycles between subsequent auto-repeat pulses (used only with macro).

Ports:
- clock_i  input  1  system clock; all logic single-domain.
- reset_i  input  1  asynchronous, active-high reset.
- btn_raw_i  input  N_BTN  raw pad levels, asynchronous to clock_i.
- btn_level_o  output  N_BTN  debounced level, 1 = pressed (polarity normalised).
- btn_press_o  output  N_BTN  1-cycle pulse on accepted press.
- btn_release_o  output  N_BTN  1-cycle pulse on accepted release.

Behaviour:
- Interface fixed: one clock, clock_i; reset_i asynchronous, active-high.
- Reset state:
  - all outputs 0.
  - synchroniser flops preset to the inactive raw level, so reset release never produces a false press.
  - FSM in IDLE; counter 0.
- Per channel:
  - 2-flop synchroniser, then polarity normalisation, giving s (1 = pressed).
- Per-channel FSM, registered outputs:
  - IDLE (released): s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: s=0 -> IDLE, cnt=0 (bounce rejected, no pulse). s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, level=1, press pulse. Otherwise cnt++.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: s=1 -> PRESSED, cnt=0 (no pulse). s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, level=0, release pulse. Otherwise cnt++.
- Latency:
  - clean edge: press_o/level_o rise exactly DEBOUNCE_CYCLES+3 clocks after the first clock edge that samples the raw input active.
  - release is symmetric.
- Pulse width:
  - press_o and release_o are exactly 1 cycle.
  - press and release of the same channel never coincide.
  - a glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Counter: width $clog2(DEBOUNCE_CYCLES); never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Channels are fully independent; simultaneous presses on several channels pulse in the same cycle.
- Reset mid-debounce or mid-press: immediate return to reset state, no pulse on deassert. A button still held after reset produces a normal press after the full latency.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - in PRESSED, a hold counter runs.
  - first extra press_o pulse at REPEAT_DELAY cycles after the accepted press, then one every REPEAT_PERIOD cycles while held.
  - leaving PRESSED clears the hold counter; a RELEASE_WAIT bounce back to PRESSED restarts it from 0.
- Undefined: exactly one press_o pulse per accepted press; hold counter and REPEAT_* logic absent.

Decomposition:
- Package btn_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3.
  - default timing constants derived from the 27 MHz board clock.
- Sub-module btn_debounce:
  - single channel: synchroniser, FSM, counter, auto-repeat.
  - instantiated N_BTN times via generate in btn_conditioner.
  - btn_conditioner itself only fans out parameters and concatenates outputs.

Test Plan (sim with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, BTN_ACTIVE_LOW=1):
- Reset: assert reset_i mid-cycle with btn_raw_i=2'b11 -> all outputs 0 asynchronously; no pulses for 20 cycles after release.
- Clean press: btn_raw_i[0] 1->0 held 20 cycles -> btn_press_o[0] high for exactly one cycle, 7 cycles after the first sampling edge; btn_level_o[0]=1 from the same cycle.
- Bounce: btn_raw_i[0] toggles 0/1 every 2 cycles for 10 cycles, then held low -> exactly one press pulse, 7 cycles after the final stable low.
- Release plus simultaneous channels: both bits pressed together, then released together -> press_o=2'b11 in one cycle; later release_o=2'b11 in one cycle, 7 cycles after release.
- Reset mid-debounce: reset_i pulsed at cnt=2 with the button held -> no pulse during or after reset; press pulse 7 cycles after reset_i deasserts.
- BTN_AUTOREPEAT_EN defined, button held 50 cycles -> press pulses at accept cycle T, T+20, T+28, T+36, T+44; none after release. Undefined -> pulse at T only.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the pushbutton conditioning path.
//   - btn_state_e : per-channel debounce FSM state encoding
//   - DEF_*       : default timing constants for the 27 MHz board clock
//   - clog2_min1  : counter-width helper that never returns a zero width
// No ports (package).
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned CLK_HZ              = 27_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;     // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;    // 100 ms

    // Width able to hold 0..n-1, at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One pushbutton channel: 2-flop synchroniser, polarity normalisation,
// debounce FSM with a stability counter, and a one-deep output register.
// Optional auto-repeat of the press pulse while held, enabled by defining
// the macro BTN_AUTOREPEAT_EN.
// Ports:
//   clock_i    in   system clock
//   reset_i    in   asynchronous active-high reset
//   btn_raw_i  in   raw pad level, asynchronous to clock_i
//   level_o    out  debounced level, 1 = pressed
//   press_o    out  1-cycle pulse on accepted press (and on auto-repeat)
//   release_o  out  1-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_debounce: illegal timing parameter");
    end

    localparam int unsigned     CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RAW_IDLE = BTN_ACTIVE_LOW;

    // Synchroniser presets to the released pad level so leaving reset
    // cannot look like a press.
    logic [1:0] sync_q;
    logic       s;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) sync_q <= {2{RAW_IDLE}};
        else         sync_q <= {sync_q[0], btn_raw_i};
    end

    assign s = sync_q[1] ^ RAW_IDLE;

    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned       HOLD_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned       HOLD_W    = clog2_min1(HOLD_MAXV);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PER_LAST  = HOLD_W'(REPEAT_PERIOD - 1);
    logic [HOLD_W-1:0] hold_cnt;
    logic              rep_phase;   // 0: waiting out the initial delay, 1: periodic
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_PRESSED;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        hold_cnt  <= '0;
                        rep_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        hold_cnt  <= '0;
                        rep_phase <= 1'b0;
                    end else if (rep_phase ? (hold_cnt == PER_LAST) : (hold_cnt == DLY_LAST)) begin
                        press_q   <= 1'b1;
                        hold_cnt  <= '0;
                        rep_phase <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        // Bounce back to held; hold counter is already 0.
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: outputs leave flops only, and the raw-sample to
    // output latency comes to DEBOUNCE_CYCLES+3 clocks.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            level_o   <= level_q;
            press_o   <= press_q;
            release_o <= release_q;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Synchronises and debounces N_BTN independent pushbuttons, producing clean
// levels and single-cycle press/release pulses. Optional auto-repeat of the
// press pulse is enabled by defining the macro BTN_AUTOREPEAT_EN.
// Ports:
//   clock_i        in   system clock (single domain)
//   reset_i        in   asynchronous active-high reset
//   btn_raw_i      in   [N_BTN] raw pad levels, asynchronous
//   btn_level_o    out  [N_BTN] debounced level, 1 = pressed
//   btn_press_o    out  [N_BTN] 1-cycle pulse per accepted press
//   btn_release_o  out  [N_BTN] 1-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_deb (
            .clock_i   (clock_i),
            .reset_i   (reset_i),
            .btn_raw_i (btn_raw_i[i]),
            .level_o   (btn_level_o[i]),
            .press_o   (btn_press_o[i]),
            .release_o (btn_release_o[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Randomised plus directed stimulus against a behavioural model. The model
// works on raw samples: a change is accepted once the raw input has disagreed
// with the accepted level for DEBOUNCE_CYCLES+1 consecutive clock samples, and
// the resulting pulse is due DEBOUNCE_CYCLES+3 clocks after the first of those
// samples (3 clocks after the last). Expected pulses go into a scoreboard
// queue; a monitor compares DUT outputs against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N     = 2;
    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RPER  = 8;
    localparam bit ALOW  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lvl;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .BTN_ACTIVE_LOW  (ALOW),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .btn_raw_i     (btn_raw),
        .btn_level_o   (btn_level),
        .btn_press_o   (btn_press),
        .btn_release_o (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    function automatic void chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        else             n_pass++;
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        else            n_pass++;
    endfunction

    // ---------------- reference model (runs on every rising edge) ----------
    bit           acc[N];
    int           run[N];
    int           streak[N];
    bit           act_s;
    logic [N-1:0] mp, mr, ml;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                for (int c = 0; c < N; c++) begin
                    acc[c] = 1'b0; run[c] = 0; streak[c] = 0;
                end
            end else begin
                mp = '0; mr = '0;
                for (int c = 0; c < N; c++) begin
                    act_s = ALOW ? !btn_raw[c] : btn_raw[c];
                    if (act_s != acc[c]) begin
                        run[c]++;
                        if (run[c] == DEB + 1) begin
                            acc[c]    = act_s;
                            run[c]    = 0;
                            streak[c] = 0;
                            if (act_s) mp[c] = 1'b1;
                            else       mr[c] = 1'b1;
                        end
                    end else begin
                        if (acc[c]) begin
                            if (run[c] > 0) streak[c] = 0;   // came back from a release bounce
                            else begin
                                streak[c]++;
                                if (REP_EN && streak[c] >= RDLY && (streak[c] - RDLY) % RPER == 0)
                                    mp[c] = 1'b1;
                            end
                        end
                        run[c] = 0;
                    end
                    ml[c] = acc[c];
                end
                if (mp != '0 || mr != '0) sb.push_back('{cyc + 3, mp, mr, ml});
            end
        end
    end

    // ---------------- monitor ----------------------------------------------
    logic [N-1:0] exp_lvl = '0;
    logic [N-1:0] exp_p, exp_r;
    exp_t         e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_lvl = '0;
                chk("rst_level", btn_level, '0);
                chk("rst_press", btn_press | btn_release, '0);
            end else begin
                exp_p = '0; exp_r = '0;
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk_int("missed_event_cycle", cyc, e.cyc);
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e       = sb.pop_front();
                    exp_p   = e.press;
                    exp_r   = e.rel;
                    exp_lvl = e.lvl;
                end
                chk("press", btn_press, exp_p);
                chk("release", btn_release, exp_r);
                chk("level", btn_level, exp_lvl);
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the outputs drop before any clock edge,
    // then release mid-cycle after len falling edges.
    task automatic do_reset(input int len);
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        chk("async_rst_level", btn_level, '0);
        chk("async_rst_pulse", btn_press | btn_release, '0);
        repeat (len) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '1;
        wait_cycles(3);
        #1 rst = 1'b0;
        wait_cycles(20);                      // released, no pulses expected

        @(negedge clk); btn_raw[0] = 1'b0;    // clean press on channel 0
        wait_cycles(20);
        btn_raw[0] = 1'b1;
        wait_cycles(15);

        for (int k = 0; k < 10; k++) begin    // bounce, 2-cycle toggles
            btn_raw[0] = k[1];
            @(negedge clk);
        end
        btn_raw[0] = 1'b0;
        wait_cycles(15);
        btn_raw[0] = 1'b1;
        wait_cycles(15);

        btn_raw = '0;                         // simultaneous press/release
        wait_cycles(20);
        btn_raw = '1;
        wait_cycles(20);

        btn_raw[0] = 1'b0;                    // reset in the middle of debounce
        wait_cycles(3);
        do_reset(2);
        wait_cycles(20);
        btn_raw = '0;                         // reset while levels are high
        wait_cycles(15);
        do_reset(2);
        wait_cycles(20);
        btn_raw = '1;
        wait_cycles(15);

        btn_raw[1] = 1'b0;                    // long hold (auto-repeat window)
        wait_cycles(50);
        btn_raw[1] = 1'b1;
        wait_cycles(40);

        for (int k = 0; k < 300; k++) begin   // random segments
            btn_raw = N'($urandom);
            if ($urandom_range(0, 9) == 0) wait_cycles($urandom_range(20, 45));
            else                           wait_cycles($urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
        end

        btn_raw = '1;
        wait_cycles(40);
        chk_int("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
